// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus between fetch_pc_unit (master) and imem (slave).
// One outstanding request at a time; responses carry no tag.
interface fetch_pc_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32I program counter and fetch sequencer: one imem request per instruction, held for decode until retire.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirect traps into FAULT instead of being force-aligned.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            PC_IN,
    input  logic                   redirect,
    input  logic                   inst_ack,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            PC,
    output logic [31:0]            inst,
    output logic                   inst_valid,
    output logic                   fetch_fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_VALID
`ifdef MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_drop;
    logic        w_flush;
    logic        w_retire;
    logic        w_rsp_take;
    logic [31:0] w_redirect_pc;

    // IDLE ignores flush: it only exists for the single cycle after reset release.
    assign w_flush    = flush && (r_state != ST_IDLE);
    assign w_retire   = (r_state == ST_VALID) && inst_ack && !flush;
    assign w_rsp_take = (r_state == ST_WAIT) && imem.imem_rsp_valid && !r_drop && !flush;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_redirect_pc = PC_IN;
    assign w_misaligned  = redirect && (PC_IN[1:0] != 2'b00);
`else
    assign w_redirect_pc = PC_IN & ~32'h3;
`endif

    // NOTE: every state element uses <= so all registers see pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: w_next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = ST_REQ;
            ST_REQ:   if (imem.imem_req_ready) w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    w_next_state = (r_drop || flush) ? ST_REQ : ST_VALID;
                end
            end
            ST_VALID: begin
                if (flush) begin
                    w_next_state = ST_REQ;
                end else if (inst_ack) begin
`ifdef MISALIGN_TRAP_EN
                    w_next_state = w_misaligned ? ST_FAULT : ST_REQ;
`else
                    w_next_state = ST_REQ;
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_FAULT: if (flush) w_next_state = ST_REQ;
`endif
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // A request accepted alongside flush, or a flush while waiting, leaves one response to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_inst <= 32'h0;
            r_drop <= 1'b0;
        end else begin
            if (w_flush) begin
                r_pc <= flush_pc;
            end else if (w_retire) begin
                r_pc <= redirect ? w_redirect_pc : r_pc + 32'd4;
            end

            if (w_rsp_take) begin
                r_inst <= imem.imem_rsp_data;
            end

            if (r_state == ST_REQ) begin
                if (imem.imem_req_ready && flush) r_drop <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                if (imem.imem_rsp_valid)  r_drop <= 1'b0;
                else if (flush)           r_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        imem.imem_req_valid = (r_state == ST_REQ);
        imem.imem_addr      = r_pc;
        PC                  = r_pc;
        inst                = r_inst;
        inst_valid          = (r_state == ST_VALID);
`ifdef MISALIGN_TRAP_EN
        fetch_fault         = (r_state == ST_FAULT);
`else
        fetch_fault         = 1'b0;
`endif
    end

endmodule
